// File: rtl/reconf_fir_seq_mac.sv
// Time-multiplexed FIR: one MAC per clock over a runtime tap count.
// Coefficient file and sample history are internal; the result is rounded, shifted and saturated.
// Ports:
//   iClk_12M, iRsn           clock, async active-low reset
//   iEnSample, iFirIn        sample strobe and input sample
//   iNumOfCoeff              tap count N, clamped to MAX_TAPS
//   iCoeffUpdateFlag         coefficient load mode (halts filtering)
//   iCsnRam, iWrnRam         coefficient port select / write enable (active low)
//   iAddrRam, iWrDtRam       coefficient address and data
//   oFirOut, oFirValid       filtered sample and update pulse
//   oSat, oBusy, oOverrun    saturation pulse, engine busy, dropped-strobe pulse
module reconf_fir_seq_mac #(
    parameter int DIN_W    = 3,
    parameter int COEF_W   = 16,
    parameter int DOUT_W   = 16,
    parameter int MAX_TAPS = 40,
    parameter int ACC_W    = 25,
    parameter int SHIFT    = 0,
    localparam int AW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1,
    localparam int NW = $clog2(MAX_TAPS + 1)
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iEnSample,
    input  logic              iCoeffUpdateFlag,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [AW-1:0]     iAddrRam,
    input  logic [COEF_W-1:0] iWrDtRam,
    input  logic [NW-1:0]     iNumOfCoeff,
    input  logic [DIN_W-1:0]  iFirIn,
    output logic [DOUT_W-1:0] oFirOut,
    output logic              oFirValid,
    output logic              oSat,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int PW = DIN_W + COEF_W;
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [DOUT_W-1:0] DMAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] DMIN = {1'b1, {(DOUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic signed [COEF_W-1:0]  r_coeff [MAX_TAPS];
    logic signed [DIN_W-1:0]   r_x     [MAX_TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [NW-1:0]             r_nl;
    logic [NW-1:0]             r_k;
    logic [DOUT_W-1:0]         r_out;
    logic                      r_valid;
    logic                      r_sat;

    logic                      w_start;
    logic                      w_coef_we;
    logic [NW-1:0]             w_nl;
    logic [AW-1:0]             w_idx;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W:0]     w_rnd;
    logic signed [ACC_W:0]     w_shr;
    logic signed [DOUT_W-1:0]  w_res;
    logic                      w_clip;

    // Load mode overrides everything: no start, no overrun report.
    assign w_start   = (r_state == S_IDLE) && iEnSample && !iCoeffUpdateFlag;
    assign oOverrun  = (r_state != S_IDLE) && iEnSample && !iCoeffUpdateFlag;
    assign oBusy     = (r_state != S_IDLE);
    assign w_coef_we = iCoeffUpdateFlag && !iCsnRam && !iWrnRam
                       && (int'(iAddrRam) < MAX_TAPS);
    assign w_nl      = (iNumOfCoeff > NW'(MAX_TAPS)) ? NW'(MAX_TAPS) : iNumOfCoeff;
    assign w_idx     = r_k[AW-1:0];
    assign w_prod    = PW'(r_coeff[w_idx]) * PW'(r_x[w_idx]);

    // One extra bit so the rounding offset cannot wrap.
    assign w_rnd = (ACC_W+1)'(r_acc) + RND;
    assign w_shr = w_rnd >>> SHIFT;

    always_comb begin
        w_clip = 1'b0;
        w_res  = w_shr[DOUT_W-1:0];
        if (w_shr > (ACC_W+1)'(DMAX)) begin
            w_res  = DMAX;
            w_clip = 1'b1;
        end else if (w_shr < (ACC_W+1)'(DMIN)) begin
            w_res  = DMIN;
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = (w_nl == '0) ? S_OUT : S_MAC;
            S_MAC:   if (r_k + NW'(1) == r_nl) w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (iCoeffUpdateFlag) w_next = S_IDLE;
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < MAX_TAPS; i++) r_coeff[i] <= '0;
        end else if (w_coef_we) begin
            r_coeff[iAddrRam] <= iWrDtRam;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < MAX_TAPS; i++) r_x[i] <= '0;
        end else if (iCoeffUpdateFlag) begin
            for (int i = 0; i < MAX_TAPS; i++) r_x[i] <= '0;
        end else if (w_start) begin
            r_x[0] <= iFirIn;
            for (int i = 1; i < MAX_TAPS; i++) r_x[i] <= r_x[i-1];
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_acc <= '0;
            r_nl  <= '0;
            r_k   <= '0;
        end else if (w_start) begin
            r_acc <= '0;
            r_nl  <= w_nl;
            r_k   <= '0;
        end else if (r_state == S_MAC && !iCoeffUpdateFlag) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_k   <= r_k + NW'(1);
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            if (r_state == S_OUT && !iCoeffUpdateFlag) begin
                r_out   <= w_res;
                r_valid <= 1'b1;
                r_sat   <= w_clip;
            end
        end
    end

    assign oFirOut   = r_out;
    assign oFirValid = r_valid;
    assign oSat      = r_sat;

endmodule

// File: tb/tb_reconf_fir_seq_mac.sv
// Bench for reconf_fir_seq_mac: default instance plus a SHIFT=2 instance on shared inputs.
// A reference model pushes expected results at each accepted strobe; a monitor pops them.
module tb_reconf_fir_seq_mac;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        ens = 1'b0;
    logic        flag = 1'b0;
    logic        csn = 1'b1;
    logic        wrn = 1'b1;
    logic [5:0]  addr = '0;
    logic [15:0] wdt = '0;
    logic [5:0]  ncoef = '0;
    logic [2:0]  fin = '0;

    logic [15:0] o0, o2;
    logic        v0, v2, s0, s2, b0, b2, ov0, ov2;

    reconf_fir_seq_mac u_dut (
        .iClk_12M(clk), .iRsn(rsn), .iEnSample(ens),
        .iCoeffUpdateFlag(flag), .iCsnRam(csn), .iWrnRam(wrn),
        .iAddrRam(addr), .iWrDtRam(wdt), .iNumOfCoeff(ncoef),
        .iFirIn(fin), .oFirOut(o0), .oFirValid(v0), .oSat(s0),
        .oBusy(b0), .oOverrun(ov0)
    );

    reconf_fir_seq_mac #(.SHIFT(2)) u_dut_s2 (
        .iClk_12M(clk), .iRsn(rsn), .iEnSample(ens),
        .iCoeffUpdateFlag(flag), .iCsnRam(csn), .iWrnRam(wrn),
        .iAddrRam(addr), .iWrDtRam(wdt), .iNumOfCoeff(ncoef),
        .iFirIn(fin), .oFirOut(o2), .oFirValid(v2), .oSat(s2),
        .oBusy(b2), .oOverrun(ov2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [15:0] o0;
        bit                 s0;
        logic signed [15:0] o2;
        bit                 s2;
        int                 due;
    } exp_t;

    exp_t   sbq[$];
    longint m_coef[40];
    longint m_x[40];
    int     busy_until = 0;
    logic signed [15:0] last0 = '0;
    logic signed [15:0] last2 = '0;

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    function automatic void mk(input longint acc, input int sh,
                               output logic signed [15:0] o, output bit s);
        longint r;
        r = (acc + ((longint'(1) << sh) >> 1)) >>> sh;
        s = 1'b0;
        if (r > 32767) begin
            o = 16'sh7fff;
            s = 1'b1;
        end else if (r < -32768) begin
            o = 16'sh8000;
            s = 1'b1;
        end else begin
            o = 16'(r);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rsn) begin
            if (v0 || v2) begin
                if (sbq.size() == 0) begin
                    fail_now("spurious_valid");
                end else begin
                    e = sbq.pop_front();
                    check("valid0", v0, 1);
                    check("valid2", v2, 1);
                    check("out0", $signed(o0), e.o0);
                    check("sat0", s0, e.s0);
                    check("out2", $signed(o2), e.o2);
                    check("sat2", s2, e.s2);
                    check("latency", cyc, e.due);
                    last0 = o0;
                    last2 = o2;
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                fail_now("valid_timeout");
                void'(sbq.pop_front());
            end
            if ((s0 && !v0) || (s2 && !v2)) fail_now("sat_without_valid");
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int x, input int n);
        bit     bsy;
        int     nl;
        longint acc;
        logic signed [2:0] tx;
        exp_t   e;
        fin   = 3'(x);
        ncoef = 6'(n);
        ens   = 1'b1;
        #1;
        bsy = (cyc < busy_until);
        check("overrun", ov0, bsy);
        check("busy", b0, bsy);
        if (!bsy) begin
            for (int i = 39; i > 0; i--) m_x[i] = m_x[i-1];
            tx = 3'(x);
            m_x[0] = tx;
            nl  = (n > 40) ? 40 : n;
            acc = 0;
            for (int i = 0; i < nl; i++) acc += m_coef[i] * m_x[i];
            acc = (acc <<< 39) >>> 39;
            mk(acc, 0, e.o0, e.s0);
            mk(acc, 2, e.o2, e.s2);
            e.due = cyc + nl + 2;
            sbq.push_back(e);
            busy_until = cyc + nl + 2;
        end
        tick(1);
        ens = 1'b0;
    endtask

    // Entering load mode aborts any result not yet visible.
    task automatic enter_load();
        flag = 1'b1;
        for (int i = 0; i < 40; i++) m_x[i] = 0;
        while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
        if (busy_until > cyc + 1) busy_until = cyc + 1;
    endtask

    task automatic wr(input int a, input int d);
        logic signed [15:0] t;
        csn  = 1'b0;
        wrn  = 1'b0;
        addr = 6'(a);
        wdt  = 16'(d);
        t    = 16'(d);
        if (flag && a < 40) m_coef[a] = t;
        tick(1);
        csn = 1'b1;
        wrn = 1'b1;
    endtask

    typedef struct {
        int x;
        int n;
        int exp;
    } vec_t;

    vec_t t1[11];

    initial begin
        for (int i = 0; i < 40; i++) begin
            m_coef[i] = 0;
            m_x[i]    = 0;
        end
        for (int i = 0; i < 11; i++) begin
            t1[i].x   = (i == 0) ? 1 : 0;
            t1[i].n   = 10;
            t1[i].exp = (i < 10) ? i + 1 : 0;
        end

        tick(3);
        check("rst_out", o0, 0);
        check("rst_valid", v0, 0);
        check("rst_sat", s0, 0);
        check("rst_busy", b0, 0);
        check("rst_overrun", ov0, 0);
        rsn = 1'b1;
        tick(2);

        // T1 impulse
        enter_load();
        for (int k = 0; k < 10; k++) wr(k, k + 1);
        flag = 1'b0;
        tick(2);
        for (int i = 0; i < 11; i++) begin
            strobe(t1[i].x, t1[i].n);
            tick(19);
            check("t1_tab", last0, t1[i].exp);
        end

        // T2 saturation, strobes back-to-back at the 42-clock period
        enter_load();
        for (int k = 0; k < 40; k++) wr(k, 16'h7fff);
        flag = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            strobe(-4, 40);
            tick(41);
        end
        check("t2_clamp", last0, -32768);

        // T3 abort mid-MAC
        enter_load();
        for (int k = 0; k < 10; k++) wr(k, k + 1);
        flag = 1'b0;
        tick(2);
        strobe(2, 10);
        tick(19);
        strobe(3, 10);
        tick(19);
        strobe(1, 10);
        tick(4);
        enter_load();
        tick(1);
        check("t3_busy", b0, 0);
        ens = 1'b1;
        #1;
        check("t3_flag_ovr", ov0, 0);
        ens = 1'b0;
        flag = 1'b0;
        tick(2);
        strobe(3, 10);
        tick(19);
        check("t3_first", last0, 3);

        // T4 overrun with N=30 every 20 clocks
        for (int i = 0; i < 6; i++) begin
            strobe((i % 2 == 0) ? 3 : -2, 30);
            tick(19);
        end
        tick(20);

        // T5 N=0 and N above MAX_TAPS
        strobe(2, 0);
        tick(9);
        check("t5_zero", last0, 0);
        strobe(1, 45);
        tick(50);

        // T6 rounding and ignored writes
        enter_load();
        wr(0, 6);
        wr(40, 16'h1234);
        flag = 1'b0;
        tick(1);
        wr(0, 99);
        tick(2);
        strobe(1, 1);
        tick(9);
        check("t6_pos0", last0, 6);
        check("t6_pos2", last2, 2);
        strobe(-1, 1);
        tick(9);
        check("t6_neg0", last0, -6);
        check("t6_neg2", last2, -1);

        // random traffic
        enter_load();
        for (int k = 0; k < 16; k++) wr(k, int'($urandom_range(0, 65535)));
        flag = 1'b0;
        tick(2);
        for (int i = 0; i < 25; i++) begin
            strobe(int'($urandom_range(0, 7)), int'($urandom_range(0, 16)));
            tick(int'($urandom_range(3, 22)));
        end
        tick(30);

        // reset in the middle of a MAC
        strobe(3, 40);
        tick(10);
        rsn = 1'b0;
        #1;
        check("rst_mid_busy", b0, 0);
        check("rst_mid_out", o0, 0);
        check("rst_mid_valid", v0, 0);
        for (int i = 0; i < 40; i++) begin
            m_coef[i] = 0;
            m_x[i]    = 0;
        end
        sbq.delete();
        busy_until = 0;
        tick(2);
        rsn = 1'b1;
        tick(50);
        strobe(2, 5);
        tick(20);
        check("post_rst_out", last0, 0);

        tick(5);
        check("sbq_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
